// File: rtl/net_recv_pkt_arbiter_pkg.sv
// Shared types and helpers for the NET_RECV packet arbiter.
package net_recv_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDrain
  } arb_state_t;

  localparam int unsigned CntW = 16;

  function automatic int unsigned rr_wrap(input int unsigned base, input int unsigned off,
                                          input int unsigned ports);
    return (base + off) % ports;
  endfunction

endpackage

// File: rtl/net_recv_pkt_arbiter_if.sv
// AXI-Stream bundle with Lanes parallel sources sharing one ID field.
interface net_recv_pkt_arbiter_if #(
  parameter int unsigned Lanes     = 1,
  parameter int unsigned DataWidth = 512,
  parameter int unsigned KeepWidth = DataWidth / 8,
  parameter int unsigned IdWidth   = 1
);

  logic [Lanes*DataWidth-1:0] tdata;
  logic [Lanes*KeepWidth-1:0] tkeep;
  logic [Lanes-1:0]           tvalid;
  logic [Lanes-1:0]           tlast;
  logic [Lanes-1:0]           tready;
  logic [IdWidth-1:0]         tid;

  modport master (
    output tdata,
    output tkeep,
    output tvalid,
    output tlast,
    output tid,
    input  tready
  );

  // Sources carry no ID; the arbiter assigns it from the grant.
  modport slave (
    input  tdata,
    input  tkeep,
    input  tvalid,
    input  tlast,
    output tready
  );

endinterface

// File: rtl/net_recv_rr_pick.sv
// Combinational round-robin pick: first set request at or after ptr_i, wrapping.
module net_recv_rr_pick
  import net_recv_arb_pkg::*;
#(
  parameter int unsigned PORTS = 4,
  parameter int unsigned ID_W  = $clog2(PORTS)
) (
  input  logic [PORTS-1:0] req_i,
  input  logic [ID_W-1:0]  ptr_i,
  output logic             valid_o,
  output logic [ID_W-1:0]  idx_o
);

  logic [PORTS-1:0] req_rot;
  int unsigned      off;

  always_comb begin
    // Rotate so that bit 0 is the port at ptr_i.
    req_rot = PORTS'({req_i, req_i} >> ptr_i);
    valid_o = 1'b0;
    off     = 0;
    for (int k = 0; k < PORTS; k++) begin
      if (!valid_o && req_rot[k]) begin
        valid_o = 1'b1;
        off     = k;
      end
    end
    idx_o = ID_W'(rr_wrap(32'(ptr_i), off, PORTS));
  end

endmodule

// File: rtl/net_recv_pkt_arbiter.sv
// Packet-granular round-robin arbiter feeding one NET_RECV handler AXIS input,
// with maximum-length truncation and per-port packet/error counters.
module net_recv_pkt_arbiter
  import net_recv_arb_pkg::*;
#(
  parameter int unsigned PORTS           = 4,
  parameter int unsigned AXIS_DATA_WIDTH = 512,
  parameter int unsigned AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH / 8,
  parameter int unsigned MAX_BEATS       = 64,
  parameter int unsigned ID_W            = $clog2(PORTS)
) (
  input  logic                    clk,
  input  logic                    rst,
  net_recv_pkt_arbiter_if.slave   s_axis,
  net_recv_pkt_arbiter_if.master  m_axis,
  output logic [PORTS*CntW-1:0]   pkt_count,
  output logic [PORTS*CntW-1:0]   err_count
);

  localparam int unsigned     BeatW    = $clog2(MAX_BEATS);
  localparam logic [BeatW-1:0] LastBeat = BeatW'(MAX_BEATS - 1);
  localparam logic [ID_W-1:0]  LastPort = ID_W'(PORTS - 1);

  arb_state_t       state_q, state_d;
  logic [ID_W-1:0]  grant_q, grant_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [BeatW-1:0] beat_cnt_q, beat_cnt_d;
  logic [CntW-1:0]  pkt_cnt_q [PORTS];
  logic [CntW-1:0]  pkt_cnt_d [PORTS];
  logic [CntW-1:0]  err_cnt_q [PORTS];
  logic [CntW-1:0]  err_cnt_d [PORTS];

  logic [AXIS_DATA_WIDTH-1:0] src_data [PORTS];
  logic [AXIS_KEEP_WIDTH-1:0] src_keep [PORTS];

  logic            pick_valid;
  logic [ID_W-1:0] pick_idx;
  logic            src_valid, src_last;
  logic            beat_acc, trunc_beat;
  logic            pkt_done, pkt_err;
  logic [ID_W-1:0] next_ptr;

  for (genvar i = 0; i < PORTS; i++) begin : g_port
    assign src_data[i]                = s_axis.tdata[i*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH];
    assign src_keep[i]                = s_axis.tkeep[i*AXIS_KEEP_WIDTH +: AXIS_KEEP_WIDTH];
    assign pkt_count[i*CntW +: CntW]  = pkt_cnt_q[i];
    assign err_count[i*CntW +: CntW]  = err_cnt_q[i];
  end

  net_recv_rr_pick #(
    .PORTS (PORTS),
    .ID_W  (ID_W)
  ) u_pick (
    .req_i   (s_axis.tvalid),
    .ptr_i   (rr_ptr_q),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  assign src_valid  = s_axis.tvalid[grant_q];
  assign src_last   = s_axis.tlast[grant_q];
  assign trunc_beat = (beat_cnt_q == LastBeat);
  assign beat_acc   = (state_q == StBusy) && src_valid && m_axis.tready[0];
  assign next_ptr   = (grant_q == LastPort) ? '0 : grant_q + 1'b1;

  // Output mux; the data path follows the grant combinationally.
  always_comb begin
    m_axis.tdata  = src_data[grant_q];
    m_axis.tkeep  = src_keep[grant_q];
    m_axis.tid    = grant_q;
    m_axis.tvalid = 1'b0;
    m_axis.tlast  = 1'b0;
    s_axis.tready = '0;
    unique case (state_q)
      StBusy: begin
        m_axis.tvalid          = src_valid;
        m_axis.tlast           = src_last | trunc_beat;
        s_axis.tready[grant_q] = m_axis.tready[0];
      end
      StDrain: begin
        s_axis.tready[grant_q] = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    pkt_done   = 1'b0;
    pkt_err    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          grant_d    = pick_idx;
          beat_cnt_d = '0;
          state_d    = StBusy;
        end
      end
      StBusy: begin
        if (beat_acc) begin
          // A real tlast on the final legal beat wins over truncation.
          if (src_last) begin
            pkt_done = 1'b1;
            rr_ptr_d = next_ptr;
            state_d  = StIdle;
          end else if (trunc_beat) begin
            pkt_done = 1'b1;
            pkt_err  = 1'b1;
            state_d  = StDrain;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end
      StDrain: begin
        if (src_valid && src_last) begin
          rr_ptr_d = next_ptr;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    for (int i = 0; i < PORTS; i++) begin
      pkt_cnt_d[i] = pkt_cnt_q[i];
      err_cnt_d[i] = err_cnt_q[i];
      if (grant_q == ID_W'(i)) begin
        if (pkt_done) pkt_cnt_d[i] = pkt_cnt_q[i] + 1'b1;
        if (pkt_err)  err_cnt_d[i] = err_cnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
      for (int i = 0; i < PORTS; i++) begin
        pkt_cnt_q[i] <= '0;
        err_cnt_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
      for (int i = 0; i < PORTS; i++) begin
        pkt_cnt_q[i] <= pkt_cnt_d[i];
        err_cnt_q[i] <= err_cnt_d[i];
      end
    end
  end

endmodule

// File: tb/tb_net_recv_pkt_arbiter.sv
// Directed bench for net_recv_pkt_arbiter: vector table plus multi-cycle sequences.
module tb_net_recv_pkt_arbiter;

  localparam int unsigned P  = 4;
  localparam int unsigned DW = 512;
  localparam int unsigned KW = 64;
  localparam int unsigned MB = 64;
  localparam int unsigned IW = 2;

  logic clk = 1'b0;
  logic rst;
  logic [P*16-1:0] pkt_count;
  logic [P*16-1:0] err_count;

  always #5 clk = ~clk;

  net_recv_pkt_arbiter_if #(.Lanes(P), .DataWidth(DW), .KeepWidth(KW), .IdWidth(IW)) s_if ();
  net_recv_pkt_arbiter_if #(.Lanes(1), .DataWidth(DW), .KeepWidth(KW), .IdWidth(IW)) m_if ();

  net_recv_pkt_arbiter #(
    .PORTS           (P),
    .AXIS_DATA_WIDTH (DW),
    .AXIS_KEEP_WIDTH (KW),
    .MAX_BEATS       (MB),
    .ID_W            (IW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .s_axis    (s_if),
    .m_axis    (m_if),
    .pkt_count (pkt_count),
    .err_count (err_count)
  );

  typedef struct {
    logic [3:0] vld;
    logic [3:0] lst;
    logic       mr;
    logic       ev;
    logic [1:0] etid;
    logic       el;
    logic [3:0] esr;
  } vec_t;

  int checks = 0;
  int errors = 0;
  vec_t tbl [14];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    s_if.tvalid = '0;
    s_if.tlast = '0;
    m_if.tready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Sends one packet of len beats on port; bg ports offer single-beat packets throughout.
  task automatic send_pkt(input int port, input int len, input logic [3:0] bg,
                          output int ob, output int lastat, output int drained);
    int b = 0;
    int cyc = 0;
    ob = 0;
    lastat = 0;
    drained = 0;
    while (b < len && cyc < 400) begin
      @(negedge clk);
      s_if.tvalid = bg | (4'b0001 << port);
      s_if.tlast  = bg | ((b == len - 1) ? (4'b0001 << port) : 4'b0000);
      m_if.tready = 1'b1;
      #1;
      if (m_if.tvalid[0] && m_if.tid == IW'(port)) begin
        ob++;
        if (m_if.tlast[0] && lastat == 0) lastat = ob;
      end
      if (s_if.tready[port] && !m_if.tvalid[0]) drained++;
      if (s_if.tready[port]) b++;
      cyc++;
    end
    check($sformatf("pkt_p%0d_len%0d_done", port, len), 64'(b), 64'(len));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int ob, la, dr, pk, cyc, acc, got;
    logic [3:0] ph;

    rst = 1'b1;
    s_if.tvalid = '0;
    s_if.tlast = '0;
    m_if.tready = 1'b1;
    for (int i = 0; i < P; i++) begin
      s_if.tdata[i*DW +: DW] = DW'(32'hC0DE_0000 + i);
      s_if.tkeep[i*KW +: KW] = KW'(1) << i;
    end

    //           vld      lst      mr    ev    tid   el    sready
    tbl[0]  = '{4'b0000, 4'b0000, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0000};
    tbl[1]  = '{4'b0001, 4'b0000, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0000};
    tbl[2]  = '{4'b0001, 4'b0000, 1'b1, 1'b1, 2'd0, 1'b0, 4'b0001};
    tbl[3]  = '{4'b0001, 4'b0000, 1'b1, 1'b1, 2'd0, 1'b0, 4'b0001};
    tbl[4]  = '{4'b0001, 4'b0001, 1'b1, 1'b1, 2'd0, 1'b1, 4'b0001};
    tbl[5]  = '{4'b0110, 4'b0000, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0000};
    tbl[6]  = '{4'b0110, 4'b0000, 1'b0, 1'b1, 2'd1, 1'b0, 4'b0000};
    tbl[7]  = '{4'b0110, 4'b0000, 1'b1, 1'b1, 2'd1, 1'b0, 4'b0010};
    tbl[8]  = '{4'b0100, 4'b0000, 1'b1, 1'b0, 2'd1, 1'b0, 4'b0010};
    tbl[9]  = '{4'b0110, 4'b0000, 1'b0, 1'b1, 2'd1, 1'b0, 4'b0000};
    tbl[10] = '{4'b0110, 4'b0010, 1'b1, 1'b1, 2'd1, 1'b1, 4'b0010};
    tbl[11] = '{4'b0100, 4'b0100, 1'b1, 1'b0, 2'd1, 1'b0, 4'b0000};
    tbl[12] = '{4'b0100, 4'b0100, 1'b1, 1'b1, 2'd2, 1'b1, 4'b0100};
    tbl[13] = '{4'b0000, 4'b0000, 1'b1, 1'b0, 2'd2, 1'b0, 4'b0000};

    do_reset();
    check("reset_pkt_count", pkt_count, 64'd0);
    check("reset_err_count", err_count, 64'd0);

    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      s_if.tvalid = tbl[k].vld;
      s_if.tlast  = tbl[k].lst;
      m_if.tready = tbl[k].mr;
      #1;
      check($sformatf("vec%0d_ctrl", k),
            64'({m_if.tvalid, m_if.tid, m_if.tlast, s_if.tready}),
            64'({tbl[k].ev, tbl[k].etid, tbl[k].el, tbl[k].esr}));
      if (tbl[k].ev) begin
        check($sformatf("vec%0d_data", k), m_if.tdata[63:0],
              64'(32'hC0DE_0000 + 32'(tbl[k].etid)));
        check($sformatf("vec%0d_keep", k), m_if.tkeep, 64'(1) << tbl[k].etid);
      end
    end
    check("table_pkt_count", pkt_count, {16'd0, 16'd1, 16'd1, 16'd1});
    check("table_err_count", err_count, 64'd0);

    // Fairness: all ports offer 2-beat packets back to back.
    do_reset();
    ph = '0;
    pk = 0;
    cyc = 0;
    while (pk < 8 && cyc < 100) begin
      @(negedge clk);
      s_if.tvalid = '1;
      s_if.tlast  = ph;
      m_if.tready = 1'b1;
      #1;
      if (m_if.tvalid[0] && m_if.tlast[0]) begin
        check($sformatf("fair_tid%0d", pk), 64'(m_if.tid), 64'(pk % 4));
        check($sformatf("fair_cycle%0d", pk), 64'(cyc), 64'(3 * pk + 2));
        pk++;
      end
      ph = ph ^ s_if.tready;
      cyc++;
    end
    check("fair_pkts", 64'(pk), 64'd8);
    @(negedge clk);
    s_if.tvalid = '0;
    #1;
    check("fair_pkt_count", pkt_count, {4{16'd2}});

    // Boundary: exactly MAX_BEATS with a real tlast is legal.
    do_reset();
    send_pkt(0, 64, 4'b0000, ob, la, dr);
    check("bound_beats", 64'(ob), 64'd64);
    check("bound_last_at", 64'(la), 64'd64);
    check("bound_drained", 64'(dr), 64'd0);
    @(negedge clk);
    s_if.tvalid = '0;
    #1;
    check("bound_err_count", err_count, 64'd0);
    check("bound_pkt0", 64'(pkt_count[15:0]), 64'd1);

    // Truncation: 70 beats from port 2 while port 3 waits.
    send_pkt(2, 70, 4'b1000, ob, la, dr);
    check("trunc_beats", 64'(ob), 64'd64);
    check("trunc_last_at", 64'(la), 64'd64);
    check("trunc_drained", 64'(dr), 64'd6);
    got = 0;
    for (int c = 0; c < 10 && got == 0; c++) begin
      @(negedge clk);
      s_if.tvalid = 4'b1000;
      s_if.tlast  = 4'b1000;
      #1;
      if (m_if.tvalid[0]) begin
        got = 1;
        check("trunc_next_tid", 64'(m_if.tid), 64'd3);
      end
    end
    check("trunc_next_seen", 64'(got), 64'd1);
    @(negedge clk);
    s_if.tvalid = '0;
    #1;
    check("trunc_err2", 64'(err_count[47:32]), 64'd1);
    check("trunc_pkt2", 64'(pkt_count[47:32]), 64'd1);

    // Reset mid-packet: move rr_ptr away from 0 first, then abort at beat 3.
    send_pkt(1, 1, 4'b0000, ob, la, dr);
    acc = 0;
    cyc = 0;
    while (acc < 2 && cyc < 20) begin
      @(negedge clk);
      s_if.tvalid = 4'b0010;
      s_if.tlast  = 4'b0000;
      #1;
      if (s_if.tready[1]) acc++;
      cyc++;
    end
    check("rst_pre_beats", 64'(acc), 64'd2);
    check("rst_pre_tid", 64'(m_if.tid), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    s_if.tvalid = '1;
    s_if.tlast  = '1;
    #1;
    check("rst_outputs", 64'({m_if.tvalid, m_if.tid, m_if.tlast, s_if.tready}), 64'd0);
    check("rst_pkt_count", pkt_count, 64'd0);
    check("rst_err_count", err_count, 64'd0);
    @(negedge clk);
    #1;
    check("rst_first_grant", 64'({m_if.tvalid, m_if.tid}), 64'({1'b1, 2'd0}));

    @(negedge clk);
    s_if.tvalid = '0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/net_recv_pkt_arbiter.md
# net_recv_pkt_arbiter

Packet-granular round-robin arbiter that shares one NET_RECV handler AXIS input (512-bit) between `PORTS` packet sources, e.g. several MAC/packet-generator lanes.

- Holds a grant from the first beat until the accepted `tlast`, so packets never interleave.
- Enforces a maximum packet length: it truncates over-long packets and drains their remainder.
- Keeps per-port accepted-packet and error counters.
- Sits directly in front of the `NET_RECV_0_*` input of the handler.

## Interface
- `PORTS`, 4: number of source ports (≥2).
- `AXIS_DATA_WIDTH`, 512: beat width.
- `AXIS_KEEP_WIDTH`, `AXIS_DATA_WIDTH/8`: keep width.
- `MAX_BEATS`, 64: longest legal packet in beats (≥2).
- `ID_W`, `$clog2(PORTS)`: source id width.

Ports. One clock; reset is synchronous and active-high:
- `clk`  in  1  clock.
- `rst`  in  1  synchronous active-high reset.
- `s_axis_tdata`  in  `PORTS*AXIS_DATA_WIDTH`  source data; port i is at slice i.
- `s_axis_tkeep`  in  `PORTS*AXIS_KEEP_WIDTH`  source keep.
- `s_axis_tvalid`  in  `PORTS`  per-port valid.
- `s_axis_tlast`  in  `PORTS`  per-port last.
- `s_axis_tready`  out  `PORTS`  per-port ready.
- `m_axis_tdata`  out  `AXIS_DATA_WIDTH`  data to the handler.
- `m_axis_tkeep`  out  `AXIS_KEEP_WIDTH`  keep to the handler.
- `m_axis_tvalid`  out  1  valid to the handler.
- `m_axis_tlast`  out  1  last to the handler.
- `m_axis_tid`  out  `ID_W`  granted source index.
- `m_axis_tready`  in  1  handler ready.
- `pkt_count`  out  `PORTS*16`  packets delivered per port; wraps at 2^16.
- `err_count`  out  `PORTS*16`  truncated packets per port; wraps.

## Operation
- States:
  - IDLE: no grant.
  - BUSY: forwarding the granted port.
  - DRAIN: discarding the tail of a truncated packet.
- IDLE:
  - All `s_axis_tready`=0 and `m_axis_tvalid`=0.
  - If any `s_axis_tvalid` is high, pick the first valid port at or after `rr_ptr`, wrapping modulo `PORTS`.
  - Register it as `grant`, clear `beat_cnt`, go to BUSY.
- BUSY:
  - `m_axis_*` = slice `grant`; `m_axis_tid` = `grant`.
  - `s_axis_tready[grant]` = `m_axis_tready`; all other readies are 0.
  - A beat is accepted when `m_axis_tvalid && m_axis_tready`.
- On each accepted beat in BUSY:
  - If source `tlast`=1: `pkt_count[grant]`++, `rr_ptr` ← `grant`+1 (mod `PORTS`), go to IDLE.
  - Else if `beat_cnt`==`MAX_BEATS`-1: `m_axis_tlast` is forced to 1 on this beat. Then `pkt_count[grant]`++, `err_count[grant]`++, go to DRAIN.
  - Else `beat_cnt`++.
- DRAIN:
  - `m_axis_tvalid`=0; `s_axis_tready[grant]`=1; all other readies are 0.
  - On an accepted source beat with `tlast`=1: `rr_ptr` ← `grant`+1, go to IDLE.
- Packets reaching `tlast` exactly at beat `MAX_BEATS` are legal: the source `tlast` check takes priority over truncation.
- The source dropping `tvalid` mid-packet keeps the grant (no timeout).
- `m_axis_tvalid` never depends on `m_axis_tready`.

## Timing
- Arbitration costs one cycle: the first beat of a packet appears on `m_axis_*` the cycle after the IDLE decision. This gives one bubble between back-to-back packets.
- Data path is combinational in BUSY: zero latency from the granted source to `m_axis_*`.
- Reset values:
  - state IDLE, `rr_ptr`=0, `grant`=0, `beat_cnt`=0.
  - all counters 0.
  - `m_axis_tvalid`=0, `m_axis_tid`=0, all `s_axis_tready`=0.
- Reset mid-packet aborts immediately, with no counter update. The handler sees a packet without `tlast`; that is acceptable and documented.
- Counter increments from two different ports never coincide, since only one packet completes per cycle.
- `beat_cnt` is `$clog2(MAX_BEATS)` bits wide and never exceeds `MAX_BEATS`-1.

## Structure
- Package `net_recv_arb_pkg`:
  - `arb_state_t` enum (IDLE, BUSY, DRAIN).
  - counter width localparam (16).
- Sub-module `net_recv_rr_pick`:
  - Combinational round-robin pick of the `PORTS`-bit request vector from a pointer.
  - Outputs `valid` and `idx`.
- FSM, counters and muxing live in the top module.

## Test plan
- **Single port:** port 0 sends an 8-beat UDP packet with `m_axis_tready`=1.
  - Expect the first output beat one cycle after `tvalid`, then 8 contiguous beats with `tid`=0 and `tlast` on beat 8.
  - Expect `pkt_count[0]`=1.
- **Fairness:** ports 0–3 continuously offer 2-beat packets.
  - Expect output `tid` order 0,1,2,3,0,… with exactly one idle cycle between packets.
  - After 8 packets, expect every `pkt_count` = 2.
- **Backpressure:** port 1 sends 4 beats while `m_axis_tready` toggles 1,0,1,0.
  - Expect data stable while stalled, `s_axis_tready[1]` mirroring `m_axis_tready`, and no interleaving from port 2, which is also valid.
- **Truncation:** `MAX_BEATS`=64; port 2 sends 70 beats.
  - Expect 64 output beats with `tlast` forced on beat 64, and 6 beats drained with `m_axis_tvalid`=0.
  - Expect `err_count[2]`=1, `pkt_count[2]`=1, and the next grant goes to port 3.
- **Boundary length:** a packet of exactly 64 beats with `tlast` on beat 64.
  - Expect `err_count` unchanged and no DRAIN state.
- **Reset:** assert `rst` for one cycle at beat 3 of a packet.
  - Expect outputs and counters at reset values next cycle, `rr_ptr`=0, and port 0 granted first afterwards.
